bram_pixel_streamer: RTL and testbench
======================================

# bram_pixel_streamer

Sequential read-out engine that sits directly downstream of the address-chained framebuffer BRAM. On a start pulse it walks the BRAM read port from address 0 to PIXEL_COUNT-1 and presents each 16-bit RGB565 word as a valid/ready pixel stream to the ILI9341 bus driver. A two-entry skid FIFO absorbs the BRAM's one-cycle read latency, so back-pressure from the driver never drops or duplicates a pixel.

## Interface
- PIXEL_COUNT, 512: number of words per frame; must satisfy 1 ≤ PIXEL_COUNT ≤ 2^ADDR_BITS.
- ADDR_BITS, 9: BRAM read-address width; 8 + log2 of the chained BRAM count.

- clk  in  1  single clock for the block; also drives the BRAM rclk.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to stream a frame; ignored while busy.
- abort  in  1  synchronous cancel of the current frame.
- busy  out  1  high from accepted start until done or abort.
- done  out  1  one-cycle pulse when the final pixel of a frame is accepted.
- raddr  out  ADDR_BITS  BRAM read address.
- ren  out  1  BRAM read enable.
- rdata  in  16  BRAM read data, valid the cycle after ren is sampled.
- pix_data  out  16  pixel word at the FIFO head.
- pix_valid  out  1  FIFO non-empty.
- pix_last  out  1  pix_data is word PIXEL_COUNT-1 of the frame.
- pix_ready  in  1  driver accepts pix_data this cycle.

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE → RUN: start=1 and abort=0.
  - RUN → DRAIN: read of address PIXEL_COUNT-1 issued.
  - DRAIN → IDLE: last pixel accepted, no reads in flight; done pulses.
  - Any state → IDLE: abort=1.
- Read issue: ren=1 in RUN when (fifo_count + inflight − pop) < 2, where pop = pix_valid & pix_ready. raddr increments by 1 on each issued read. raddr returns to 0 on entering IDLE.
- rdata is pushed into the FIFO on the edge after the cycle ren was high. Each entry carries a last flag, set for address PIXEL_COUNT-1.
- The credit rule guarantees the FIFO never overflows. A push and a pop in the same cycle are both legal.
- pix_data and pix_last hold stable while pix_valid=1 and pix_ready=0.
- abort flushes the FIFO: pix_valid drops on the next edge. Any in-flight rdata is discarded, done does not pulse, and busy falls on the next edge.
- start together with abort: abort wins and start is ignored. start while busy is ignored.
- Reset values: raddr=0, ren=0, busy=0, done=0, pix_valid=0, pix_data=0, pix_last=0; state IDLE; FIFO empty. Reset asserted mid-frame abandons the frame immediately, with no done.

## Timing
- start sampled at edge E0 → ren=1, raddr=0 during cycle E0–E1.
- BRAM data follows after E1 → captured at E2 → pix_valid=1 after E2.
- Start-to-first-pixel latency is 2 cycles.
- With pix_ready held high, throughput is 1 pixel/clk. The last pixel appears PIXEL_COUNT+1 cycles after E0.
- done rises in the cycle after the accepting edge of the last pixel. busy falls on that same edge.
- Stall recovery: when pix_ready rises after a stall with the FIFO full, the next read issues in the same cycle. Streaming resumes without a bubble.

## Configuration
- BRAM_PIXEL_STREAMER_CONTINUOUS_EN defined:
  - After issuing address PIXEL_COUNT-1, raddr wraps to 0 and RUN continues without passing through DRAIN.
  - pix_last and done mark the end of every frame.
  - busy stays high until abort or rst.
- Undefined: one frame per start, as described above.

## Test plan
- PIXEL_COUNT=4, BRAM preloaded with 0x1111..0x4444, pix_ready=1, start pulse → pix_valid 2 cycles later; words 0x1111,0x2222,0x3333,0x4444 on consecutive cycles; pix_last on 0x4444; done 1 cycle after; busy low.
- Same preload, pix_ready toggling 1,0,0,1,… (random) → exact sequence 0x1111..0x4444 with no drop or duplicate. raddr never runs more than 2 ahead of accepted pixels.
- pix_ready=0 for 10 cycles after start → exactly 2 reads issued, pix_data=0x1111 held. Raising pix_ready resumes at 1 pixel/clk.
- abort after the 2nd pixel is accepted → pix_valid=0 and busy=0 next edge, no done. A following start restreams from 0x1111.
- rst pulsed mid-frame → all outputs at reset values, no done; start before completion is ignored.
- CONTINUOUS_EN, PIXEL_COUNT=4 → sequence repeats 0x1111..0x4444 across 3 frames, raddr wraps 3→0, 3 done pulses. abort stops streaming.

Source files
------------

// File: rtl/bram_pixel_streamer_if.sv
// Pixel stream from the BRAM streamer to the ILI9341 bus driver.
// valid/ready: a word transfers on a rising clk edge where pix_valid and pix_ready are both high.
interface bram_pixel_streamer_if;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_last;
  logic        pix_ready;

  modport master (output pix_data, output pix_valid, output pix_last, input pix_ready);
  modport slave  (input pix_data, input pix_valid, input pix_last, output pix_ready);
endinterface

// File: rtl/bram_pixel_streamer.sv
// Walks the framebuffer BRAM from address 0 to PIXEL_COUNT-1 and streams each word through a 2-entry skid FIFO.
// Define BRAM_PIXEL_STREAMER_CONTINUOUS_EN to loop frames until abort instead of stopping after one.
module bram_pixel_streamer #(
  parameter int PIXEL_COUNT = 512,
  parameter int ADDR_BITS   = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [ADDR_BITS-1:0] raddr_o,
  output logic                 ren_o,
  input  logic [15:0]          rdata_i,
  output logic [1:0]           state_o,
  bram_pixel_streamer_if.master pix
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(PIXEL_COUNT - 1);

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] raddr_q, raddr_d;
  logic                 inflight_q, inflight_d;
  logic                 inflight_last_q, inflight_last_d;
  logic [1:0]           count_q, count_d;
  logic [15:0]          e0_data_q, e0_data_d, e1_data_q, e1_data_d;
  logic                 e0_last_q, e0_last_d, e1_last_q, e1_last_d;
  logic                 done_q, done_d;

  logic       ren;
  logic       pop;
  logic       frame_end;
  logic [2:0] occ;

  assign pop       = (count_q != 2'd0) && pix.pix_ready;
  assign frame_end = pop && e0_last_q;
  // Occupancy the FIFO would reach if nothing new were issued: entries held plus the read in flight, minus this cycle's pop.
  assign occ       = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_i && !abort_i) state_d = S_RUN;
      S_RUN: begin
        if (abort_i) state_d = S_IDLE;
`ifndef BRAM_PIXEL_STREAMER_CONTINUOUS_EN
        else if (ren && (raddr_q == LAST_ADDR)) state_d = S_DRAIN;
`endif
      end
      S_DRAIN: begin
        if (abort_i)        state_d = S_IDLE;
        else if (frame_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ren           = (state_q == S_RUN) && !abort_i && (occ < 3'd2);
    ren_o         = ren;
    busy_o        = (state_q != S_IDLE);
    done_o        = done_q;
    raddr_o       = raddr_q;
    state_o       = state_q;
    pix.pix_data  = e0_data_q;
    pix.pix_last  = e0_last_q;
    pix.pix_valid = (count_q != 2'd0);
  end

  always_comb begin
    raddr_d         = raddr_q;
    inflight_d      = ren;
    inflight_last_d = ren && (raddr_q == LAST_ADDR);
    count_d         = count_q;
    e0_data_d       = e0_data_q;
    e0_last_d       = e0_last_q;
    e1_data_d       = e1_data_q;
    e1_last_d       = e1_last_q;
    done_d          = frame_end && !abort_i;

    if (ren) raddr_d = (raddr_q == LAST_ADDR) ? '0 : raddr_q + ADDR_BITS'(1);
    if (state_d == S_IDLE) raddr_d = '0;

    // Abort drops the FIFO contents and whatever read data lands this edge.
    if (abort_i) begin
      count_d = 2'd0;
    end else begin
      unique case ({inflight_q, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            e0_data_d = rdata_i;
            e0_last_d = inflight_last_q;
          end else begin
            e1_data_d = rdata_i;
            e1_last_d = inflight_last_q;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          e0_data_d = e1_data_q;
          e0_last_d = e1_last_q;
          count_d   = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            e0_data_d = rdata_i;
            e0_last_d = inflight_last_q;
          end else begin
            e0_data_d = e1_data_q;
            e0_last_d = e1_last_q;
            e1_data_d = rdata_i;
            e1_last_d = inflight_last_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raddr_q         <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      count_q         <= 2'd0;
      e0_data_q       <= 16'h0000;
      e0_last_q       <= 1'b0;
      e1_data_q       <= 16'h0000;
      e1_last_q       <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      raddr_q         <= raddr_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      count_q         <= count_d;
      e0_data_q       <= e0_data_d;
      e0_last_q       <= e0_last_d;
      e1_data_q       <= e1_data_d;
      e1_last_q       <= e1_last_d;
      done_q          <= done_d;
    end
  end

endmodule

// File: tb/tb_bram_pixel_streamer.sv
// Bench for bram_pixel_streamer with a 4-word frame; a behavioural BRAM and a pixel monitor feed per-scenario checks.
module tb_bram_pixel_streamer;
  localparam int N  = 4;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst, start, abort, busy, done, ren;
  logic [AW-1:0] raddr;
  logic [15:0]   rdata;
  logic [1:0]    state;
  logic [15:0]   mem [16];

  int n_chk  = 0;
  int n_fail = 0;

  bram_pixel_streamer_if pif ();

  bram_pixel_streamer #(.PIXEL_COUNT(N), .ADDR_BITS(AW)) dut (
    .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .busy_o(busy), .done_o(done),
    .raddr_o(raddr), .ren_o(ren), .rdata_i(rdata), .state_o(state), .pix(pif)
  );

  // clock / BRAM model
  always #5 clk = ~clk;
  always @(posedge clk) if (ren) rdata <= mem[raddr];

  // monitor: records every accepted pixel, done pulses, reads and flow-control violations
  int          cyc = 0;
  logic [15:0] obs_q[$];
  bit          obs_last_q[$];
  int          obs_cyc_q[$];
  int          done_total = 0, done_cyc = 0, rd_total = 0;
  int          fo = 0, max_out = 0, hold_err = 0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_data = 16'h0;
  bit          prev_last = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pif.pix_valid && pif.pix_ready) begin
      obs_q.push_back(pif.pix_data);
      obs_last_q.push_back(pif.pix_last);
      obs_cyc_q.push_back(cyc);
    end
    if (done) begin done_total++; done_cyc = cyc; end
    if (ren) rd_total++;
    if (prev_stall && !rst && (!pif.pix_valid || pif.pix_data !== prev_data || pif.pix_last !== prev_last))
      hold_err++;
    if (rst || !busy) fo = 0;
    else begin
      fo += int'(ren) - int'(pif.pix_valid && pif.pix_ready);
      if (fo > max_out) max_out = fo;
    end
    prev_stall = pif.pix_valid && !pif.pix_ready && !abort && !rst;
    prev_data  = pif.pix_data;
    prev_last  = pif.pix_last;
  end

  // driver tasks
  task automatic pulse_start();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    #1;
  endtask

  task automatic wait_obs(input int target, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk); #1;
      if (obs_q.size() >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic stream_frame(input int max_cyc, output bit ok);
    ok = 1'b0;
    pulse_start();
    for (int k = 0; k < max_cyc; k++) begin
      pif.pix_ready = 1'($urandom_range(0, 1));
      start = (k == 2);
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    start = 1'b0;
    #1;
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; pif.pix_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_chk++; if (ren !== 1'b0) begin n_fail++; $display("FAIL reset_ren: got %b expected 0", ren); end
    n_chk++; if (raddr !== '0) begin n_fail++; $display("FAIL reset_raddr: got %0h expected 0", raddr); end
    n_chk++; if (pif.pix_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", pif.pix_valid); end
    n_chk++; if (pif.pix_data !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0000", pif.pix_data); end
    n_chk++; if (pif.pix_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b expected 0", pif.pix_last); end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_start_abort();
    int rd0;
    rd0 = rd_total;
    @(posedge clk); #1; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_abort_busy: got %b expected 0", busy); end
    n_chk++; if (rd_total != rd0) begin n_fail++; $display("FAIL start_abort_reads: got %0d expected %0d", rd_total, rd0); end
  endtask

  task automatic test_stream_ready();
    int base, d0, c0;
    bit ok;
    base = obs_q.size(); d0 = done_total;
    pif.pix_ready = 1'b1;
    pulse_start();
    c0 = cyc;
    n_chk++; if (ren !== 1'b1) begin n_fail++; $display("FAIL first_ren: got %b expected 1", ren); end
    n_chk++; if (raddr !== '0) begin n_fail++; $display("FAIL first_raddr: got %0h expected 0", raddr); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_rise: got %b expected 1", busy); end
    wait_done(20, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL stream_done_timeout: got 0 expected 1"); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_at_done: got %b expected 0", busy); end
    n_chk++; if (done_cyc != c0 + N + 2) begin n_fail++; $display("FAIL done_cycle: got %0d expected %0d", done_cyc - c0, N + 2); end
    n_chk++; if (obs_q.size() != base + N) begin n_fail++; $display("FAIL stream_count: got %0d expected %0d", obs_q.size() - base, N); end
    for (int k = 0; k < N && base + k < obs_q.size(); k++) begin
      n_chk++; if (obs_q[base+k] !== mem[k]) begin n_fail++; $display("FAIL stream_word%0d: got %h expected %h", k, obs_q[base+k], mem[k]); end
      n_chk++; if (obs_last_q[base+k] !== (k == N - 1)) begin n_fail++; $display("FAIL stream_last%0d: got %b expected %b", k, obs_last_q[base+k], k == N - 1); end
      n_chk++; if (obs_cyc_q[base+k] != c0 + 2 + k) begin n_fail++; $display("FAIL stream_cyc%0d: got %0d expected %0d", k, obs_cyc_q[base+k] - c0, 2 + k); end
    end
    @(posedge clk); #1;
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_width: got %b expected 0", done); end
    n_chk++; if (done_total - d0 != 1) begin n_fail++; $display("FAIL stream_done_count: got %0d expected 1", done_total - d0); end
    n_chk++; if (raddr !== '0) begin n_fail++; $display("FAIL idle_raddr: got %0h expected 0", raddr); end
  endtask

  task automatic test_stall();
    int base, rd0, d0;
    bit ok;
    base = obs_q.size(); rd0 = rd_total; d0 = done_total;
    pif.pix_ready = 1'b0;
    pulse_start();
    repeat (10) @(posedge clk);
    #1;
    n_chk++; if (rd_total - rd0 != 2) begin n_fail++; $display("FAIL stall_reads: got %0d expected 2", rd_total - rd0); end
    n_chk++; if (pif.pix_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b expected 1", pif.pix_valid); end
    n_chk++; if (pif.pix_data !== mem[0]) begin n_fail++; $display("FAIL stall_data: got %h expected %h", pif.pix_data, mem[0]); end
    n_chk++; if (ren !== 1'b0) begin n_fail++; $display("FAIL stall_ren_off: got %b expected 0", ren); end
    pif.pix_ready = 1'b1;
    #1;
    n_chk++; if (ren !== 1'b1) begin n_fail++; $display("FAIL stall_recover_ren: got %b expected 1", ren); end
    wait_done(20, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL stall_done_timeout: got 0 expected 1"); end
    n_chk++; if (obs_q.size() != base + N) begin n_fail++; $display("FAIL stall_count: got %0d expected %0d", obs_q.size() - base, N); end
    for (int k = 0; k < N && base + k < obs_q.size(); k++) begin
      n_chk++; if (obs_q[base+k] !== mem[k]) begin n_fail++; $display("FAIL stall_word%0d: got %h expected %h", k, obs_q[base+k], mem[k]); end
      n_chk++; if (obs_cyc_q[base+k] != obs_cyc_q[base] + k) begin n_fail++; $display("FAIL stall_rate%0d: got %0d expected %0d", k, obs_cyc_q[base+k] - obs_cyc_q[base], k); end
    end
    n_chk++; if (done_total - d0 != 1) begin n_fail++; $display("FAIL stall_done_count: got %0d expected 1", done_total - d0); end
  endtask

  task automatic test_random_backpressure();
    int base, d0;
    bit ok;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) mem[i] = 16'($urandom_range(0, 16'hffff));
      base = obs_q.size(); d0 = done_total;
      stream_frame(300, ok);
      pif.pix_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      n_chk++; if (!ok) begin n_fail++; $display("FAIL rand_done_timeout%0d: got 0 expected 1", f); end
      n_chk++; if (obs_q.size() != base + N) begin n_fail++; $display("FAIL rand_count%0d: got %0d expected %0d", f, obs_q.size() - base, N); end
      for (int k = 0; k < N && base + k < obs_q.size(); k++) begin
        n_chk++; if (obs_q[base+k] !== mem[k]) begin n_fail++; $display("FAIL rand_word%0d_%0d: got %h expected %h", f, k, obs_q[base+k], mem[k]); end
        n_chk++; if (obs_last_q[base+k] !== (k == N - 1)) begin n_fail++; $display("FAIL rand_last%0d_%0d: got %b expected %b", f, k, obs_last_q[base+k], k == N - 1); end
      end
      n_chk++; if (done_total - d0 != 1) begin n_fail++; $display("FAIL rand_done_count%0d: got %0d expected 1", f, done_total - d0); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rand_busy%0d: got %b expected 0", f, busy); end
    end
    n_chk++; if (max_out > 2) begin n_fail++; $display("FAIL read_ahead: got %0d expected <=2", max_out); end
    n_chk++; if (hold_err != 0) begin n_fail++; $display("FAIL hold_stable: got %0d expected 0", hold_err); end
  endtask

  task automatic test_abort();
    int base, d0;
    bit ok;
    for (int i = 0; i < N; i++) mem[i] = 16'h1111 * 16'(i + 1);
    base = obs_q.size(); d0 = done_total;
    pif.pix_ready = 1'b1;
    pulse_start();
    wait_obs(base + 2, 20, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL abort_wait_timeout: got 0 expected 1"); end
    @(posedge clk); #1; abort = 1'b1; pif.pix_ready = 1'b0;
    @(posedge clk); #1; abort = 1'b0;
    n_chk++; if (pif.pix_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b expected 0", pif.pix_valid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_chk++; if (raddr !== '0) begin n_fail++; $display("FAIL abort_raddr: got %0h expected 0", raddr); end
    repeat (5) @(posedge clk);
    #1;
    n_chk++; if (pif.pix_valid !== 1'b0) begin n_fail++; $display("FAIL abort_flush: got %b expected 0", pif.pix_valid); end
    n_chk++; if (done_total != d0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", done_total - d0); end
    n_chk++; if (obs_q.size() != base + 2) begin n_fail++; $display("FAIL abort_count: got %0d expected 2", obs_q.size() - base); end
    base = obs_q.size(); d0 = done_total;
    pif.pix_ready = 1'b1;
    pulse_start();
    wait_done(20, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL restream_timeout: got 0 expected 1"); end
    n_chk++; if (obs_q.size() != base + N) begin n_fail++; $display("FAIL restream_count: got %0d expected %0d", obs_q.size() - base, N); end
    for (int k = 0; k < N && base + k < obs_q.size(); k++) begin
      n_chk++; if (obs_q[base+k] !== mem[k]) begin n_fail++; $display("FAIL restream_word%0d: got %h expected %h", k, obs_q[base+k], mem[k]); end
    end
  endtask

  task automatic test_reset_midframe();
    int d0;
    bit ok;
    d0 = done_total;
    pif.pix_ready = 1'b1;
    pulse_start();
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_chk++; if (pif.pix_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", pif.pix_valid); end
    n_chk++; if (pif.pix_data !== 16'h0) begin n_fail++; $display("FAIL midrst_data: got %h expected 0000", pif.pix_data); end
    n_chk++; if (ren !== 1'b0 || raddr !== '0) begin n_fail++; $display("FAIL midrst_read: got %b/%0h expected 0/0", ren, raddr); end
    @(posedge clk); #1; rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    n_chk++; if (done_total != d0) begin n_fail++; $display("FAIL midrst_no_done: got %0d expected 0", done_total - d0); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: got %b expected 0", busy); end
    wait_done(1, ok);
  endtask

  task automatic test_continuous();
    int base, d0, c0;
    bit ok;
    for (int i = 0; i < N; i++) mem[i] = 16'h1111 * 16'(i + 1);
    base = obs_q.size(); d0 = done_total;
    pif.pix_ready = 1'b1;
    pulse_start();
    c0 = cyc;
    wait_obs(base + 3 * N, 60, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL cont_timeout: got 0 expected 1"); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cont_busy: got %b expected 1", busy); end
    @(posedge clk); #1; abort = 1'b1; pif.pix_ready = 1'b0;
    @(posedge clk); #1; abort = 1'b0;
    n_chk++; if (busy !== 1'b0 || pif.pix_valid !== 1'b0) begin n_fail++; $display("FAIL cont_abort: got %b/%b expected 0/0", busy, pif.pix_valid); end
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (done_total - d0 != 3) begin n_fail++; $display("FAIL cont_done_count: got %0d expected 3", done_total - d0); end
    n_chk++; if (obs_q.size() != base + 3 * N) begin n_fail++; $display("FAIL cont_count: got %0d expected %0d", obs_q.size() - base, 3 * N); end
    for (int k = 0; k < 3 * N && base + k < obs_q.size(); k++) begin
      n_chk++; if (obs_q[base+k] !== mem[k % N]) begin n_fail++; $display("FAIL cont_word%0d: got %h expected %h", k, obs_q[base+k], mem[k % N]); end
      n_chk++; if (obs_last_q[base+k] !== (k % N == N - 1)) begin n_fail++; $display("FAIL cont_last%0d: got %b expected %b", k, obs_last_q[base+k], k % N == N - 1); end
      n_chk++; if (obs_cyc_q[base+k] != c0 + 2 + k) begin n_fail++; $display("FAIL cont_cyc%0d: got %0d expected %0d", k, obs_cyc_q[base+k] - c0, 2 + k); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = (i < N) ? 16'h1111 * 16'(i + 1) : 16'hdead;
    test_reset();
    test_start_abort();
`ifdef BRAM_PIXEL_STREAMER_CONTINUOUS_EN
    test_continuous();
`else
    test_stream_ready();
    test_stall();
    test_abort();
    test_random_backpressure();
    test_reset_midframe();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
